// File: rtl/uart_tx_arbiter_if.sv
// Byte-producer handshake bundle shared by the requesters and the UART transmitter.
interface uart_tx_arbiter_if #(
  parameter int Requesters = 2
);
  logic [Requesters-1:0]   request;
  logic [8*Requesters-1:0] data;
  logic [Requesters-1:0]   grant;
  logic                    busy;
  logic                    frameDone;
  logic                    tx;

  modport master (output request, output data, input grant, input busy, input frameDone, input tx);
  modport slave  (input request, input data, output grant, output busy, output frameDone, output tx);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter (start, 8 data LSB first, stop bits).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_arbiter #(
  parameter int ClockFrequency = 1000000,
  parameter int BaudRate       = 9600,
  parameter int Requesters     = 2,
  parameter int StopBits       = 1
) (
  input logic              clock,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int BitTicks  = ClockFrequency / BaudRate;
  localparam int TickWidth = (BitTicks > 1) ? $clog2(BitTicks) : 1;
  localparam int PtrWidth  = (Requesters > 1) ? $clog2(Requesters) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } TxState;

  TxState                state, stateNext;
  logic [TickWidth-1:0]  tick, tickNext, tickInc;
  logic                  lastTick;
  logic [2:0]            bitIndex, bitNext, bitInc;
  logic [7:0]            shiftReg, shiftNext;
  logic [PtrWidth-1:0]   pointer, pointerNext;
  logic                  txReg, txNext;
  logic                  busyReg, busyNext;
  logic [Requesters-1:0] grantReg, grantNext;
  logic                  doneReg, doneNext;
  logic                  anyRequest, wrapFound;
  logic [PtrWidth-1:0]   sel, wrapSel;

  // Prefer the lowest requester at or above the pointer, else wrap to the lowest overall.
  always_comb begin
    anyRequest = 1'b0;
    sel        = '0;
    wrapFound  = 1'b0;
    wrapSel    = '0;
    for (int i = Requesters - 1; i >= 0; i--) begin
      if (bus.request[i]) begin
        wrapFound = 1'b1;
        wrapSel   = PtrWidth'(i);
        if (PtrWidth'(i) >= pointer) begin
          anyRequest = 1'b1;
          sel        = PtrWidth'(i);
        end
      end
    end
    if (!anyRequest) begin
      anyRequest = wrapFound;
      sel        = wrapSel;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick     <= '0;
      bitIndex <= '0;
      shiftReg <= '0;
      pointer  <= '0;
      txReg    <= 1'b1;
      busyReg  <= 1'b0;
      grantReg <= '0;
      doneReg  <= 1'b0;
    end else begin
      state    <= stateNext;
      tick     <= tickNext;
      bitIndex <= bitNext;
      shiftReg <= shiftNext;
      pointer  <= pointerNext;
      txReg    <= txNext;
      busyReg  <= busyNext;
      grantReg <= grantNext;
      doneReg  <= doneNext;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    stateNext   = state;
    tickNext    = tick;
    bitNext     = bitIndex;
    shiftNext   = shiftReg;
    pointerNext = pointer;
    txNext      = txReg;
    busyNext    = busyReg;
    grantNext   = '0;
    doneNext    = 1'b0;
    lastTick    = (tick == TickWidth'(BitTicks - 1));
    tickInc     = lastTick ? '0 : tick + TickWidth'(1);
    bitInc      = bitIndex + 3'd1;

    case (state)
      IDLE: begin
        txNext   = 1'b1;
        busyNext = 1'b0;
        tickNext = '0;
        bitNext  = '0;
        if (anyRequest) begin
          shiftNext      = bus.data[{sel, 3'b000} +: 8];
          grantNext[sel] = 1'b1;
          txNext         = 1'b0;
          busyNext       = 1'b1;
          stateNext      = START;
          pointerNext    = (sel == PtrWidth'(Requesters - 1)) ? '0 : sel + PtrWidth'(1);
        end
      end
      START: begin
        tickNext = tickInc;
        if (lastTick) begin
          stateNext = DATA;
          bitNext   = '0;
          txNext    = shiftReg[0];
        end
      end
      DATA: begin
        tickNext = tickInc;
        if (lastTick) begin
          if (bitIndex == 3'd7) begin
            bitNext = '0;
`ifdef UART_TX_PARITY_EN
            stateNext = PARITY;
            txNext    = ^shiftReg;
`else
            stateNext = STOP;
            txNext    = 1'b1;
`endif
          end else begin
            bitNext = bitInc;
            txNext  = shiftReg[bitInc];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tickNext = tickInc;
        if (lastTick) begin
          stateNext = STOP;
          bitNext   = '0;
          txNext    = 1'b1;
        end
      end
`endif
      STOP: begin
        tickNext = tickInc;
        if (lastTick) begin
          if (bitIndex == 3'(StopBits - 1)) begin
            stateNext = IDLE;
            bitNext   = '0;
            txNext    = 1'b1;
            busyNext  = 1'b0;
            doneNext  = 1'b1;
          end else begin
            bitNext = bitInc;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.tx        = txReg;
  assign bus.busy      = busyReg;
  assign bus.grant     = grantReg;
  assign bus.frameDone = doneReg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants and bytes are queued as requests are raised.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int ClockFrequency = 100;
  localparam int BaudRate       = 10;
  localparam int BitTicks       = ClockFrequency / BaudRate;
  localparam int Requesters     = 3;
`ifdef UART_TX_PARITY_EN
  localparam int StopBits   = 2;
  localparam int ParityBits = 1;
`else
  localparam int StopBits   = 1;
  localparam int ParityBits = 0;
`endif
  localparam int FrameTicks = (9 + ParityBits + StopBits) * BitTicks;
  localparam int Timeout    = 3 * FrameTicks;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] expByteQ[$];
  int         expGrantQ[$];

  uart_tx_arbiter_if #(.Requesters(Requesters)) bus ();

  uart_tx_arbiter #(
    .ClockFrequency(ClockFrequency),
    .BaudRate(BaudRate),
    .Requesters(Requesters),
    .StopBits(StopBits)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  function automatic logic modelBit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (ParityBits == 1 && slot == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic applyStimulus(input int idx, input logic [7:0] value);
    bus.data[8*idx +: 8] = value;
    bus.request[idx]     = 1'b1;
    expGrantQ.push_back(idx);
    expByteQ.push_back(value);
  endtask

  task automatic waitGrant(input int idx, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < Timeout; n++) begin
      @(negedge clock);
      if (bus.grant[idx] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitDone(output int cycles, output bit ok);
    ok     = 1'b0;
    cycles = 0;
    for (int n = 0; n < Timeout; n++) begin
      @(negedge clock);
      cycles++;
      if (bus.frameDone === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Every frame is compared cycle by cycle against the byte queued for it.
  task automatic monitorFrames();
    logic [7:0] expByte;
    bit         aborted;
    int         badCycle;
    logic       badTx, expBit;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) continue;
      if (bus.busy !== 1'b1) begin
        checks++;
        if (bus.frameDone !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stray_done actual=%b required=0 at %0t", bus.frameDone, $time);
        end
        continue;
      end
      if (expByteQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_frame busy actual=1 required=0 at %0t", $time);
        for (int n = 0; n < Timeout && bus.busy === 1'b1; n++) @(negedge clock);
        continue;
      end
      expByte  = expByteQ.pop_front();
      aborted  = 1'b0;
      badCycle = -1;
      badTx    = 1'b0;
      for (int c = 0; c < FrameTicks; c++) begin
        if (c > 0) @(negedge clock);
        if (reset !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        expBit = modelBit(expByte, c / BitTicks);
        if (badCycle < 0 && (bus.tx !== expBit || bus.busy !== 1'b1 || bus.frameDone !== 1'b0)) begin
          badCycle = c;
          badTx    = bus.tx;
        end
      end
      if (aborted) continue;
      checks++;
      if (badCycle >= 0) begin
        errors++;
        $display("[TB] FAIL frame_bits byte=%h cycle=%0d tx actual=%b required=%b (busy must stay 1, done 0)",
                 expByte, badCycle, badTx, modelBit(expByte, badCycle / BitTicks));
      end
      @(negedge clock);
      if (reset !== 1'b1) continue;
      checks++;
      if (bus.busy !== 1'b0 || bus.frameDone !== 1'b1) begin
        errors++;
        $display("[TB] FAIL frame_end byte=%h busy/done actual=%b/%b required=0/1",
                 expByte, bus.busy, bus.frameDone);
      end
    end
  endtask

  task automatic monitorGrants();
    logic [Requesters-1:0] expGrant;
    int                    g;
    forever begin
      @(negedge clock);
      if (bus.grant !== '0) begin
        checks++;
        if (expGrantQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_grant actual=%b required=000 at %0t", bus.grant, $time);
        end else begin
          g        = expGrantQ.pop_front();
          expGrant = Requesters'(1) << g;
          if (bus.grant !== expGrant) begin
            errors++;
            $display("[TB] FAIL grant_order actual=%b required=%b at %0t", bus.grant, expGrant, $time);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    bus.request = '0;
    bus.data    = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.tx, bus.busy, bus.grant, bus.frameDone} !== 6'b10_0000) begin
      errors++;
      $display("[TB] FAIL reset_values tx/busy/grant/done actual=%b/%b/%b/%b required=1/0/000/0",
               bus.tx, bus.busy, bus.grant, bus.frameDone);
    end
    reset = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      checks++;
      if ({bus.tx, bus.busy, bus.grant, bus.frameDone} !== 6'b10_0000) begin
        errors++;
        $display("[TB] FAIL idle_values cycle=%0d tx/busy/grant/done actual=%b/%b/%b/%b required=1/0/000/0",
                 n, bus.tx, bus.busy, bus.grant, bus.frameDone);
      end
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    int cycles;
    applyStimulus(0, 8'h5A);
    waitGrant(0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL single_grant actual=none required=001");
    end
    bus.request[0] = 1'b0;
    waitDone(cycles, ok);
    checks++;
    if (!ok || cycles != FrameTicks) begin
      errors++;
      $display("[TB] FAIL single_length cycles actual=%0d required=%0d (done seen=%0b)", cycles, FrameTicks, ok);
    end
  endtask

  task automatic test_round_robin();
    int  seen;
    int  cycles;
    bit  ok;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    bus.data    = {8'h33, 8'h22, 8'h11};
    bus.request = 3'b111;
    expGrantQ.push_back(0); expGrantQ.push_back(1); expGrantQ.push_back(2); expGrantQ.push_back(0);
    expByteQ.push_back(8'h11); expByteQ.push_back(8'h22); expByteQ.push_back(8'h33); expByteQ.push_back(8'h11);
    seen = 0;
    for (int n = 0; n < 5 * FrameTicks && seen < 4; n++) begin
      @(negedge clock);
      if (bus.grant !== '0) seen++;
    end
    bus.request = '0;
    checks++;
    if (seen != 4) begin
      errors++;
      $display("[TB] FAIL rr_grant_count actual=%0d required=4", seen);
    end
    waitDone(cycles, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL rr_last_done actual=timeout required=frameDone");
    end
  endtask

  task automatic test_late_request();
    bit ok;
    bit earlyGrant;
    int cycles;
    applyStimulus(0, 8'hC3);
    waitGrant(0, ok);
    bus.request[0] = 1'b0;
    repeat (30) @(negedge clock);
    applyStimulus(1, 8'h96);
    repeat (20) @(negedge clock);
    bus.data[7:0]  = 8'hFF;
    bus.request[0] = 1'b1;
    repeat (3) @(negedge clock);
    bus.request[0] = 1'b0;
    earlyGrant = 1'b0;
    ok         = 1'b0;
    for (int n = 0; n < Timeout; n++) begin
      @(negedge clock);
      if (bus.grant !== '0) earlyGrant = 1'b1;
      if (bus.frameDone === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || earlyGrant) begin
      errors++;
      $display("[TB] FAIL late_wait early grant actual=%0b required=0 (done seen=%0b)", earlyGrant, ok);
    end
    @(negedge clock);
    checks++;
    if (bus.grant !== 3'b010) begin
      errors++;
      $display("[TB] FAIL late_grant_timing actual=%b required=010", bus.grant);
    end
    bus.request[1] = 1'b0;
    waitDone(cycles, ok);
    checks++;
    if (!ok || cycles != FrameTicks) begin
      errors++;
      $display("[TB] FAIL late_length cycles actual=%0d required=%0d", cycles, FrameTicks);
    end
  endtask

  task automatic test_parity_frame();
    bit ok;
    int cycles;
    applyStimulus(2, 8'h07);
    waitGrant(2, ok);
    bus.request[2] = 1'b0;
    waitDone(cycles, ok);
    checks++;
    if (!ok || cycles != FrameTicks) begin
      errors++;
      $display("[TB] FAIL parity_length cycles actual=%0d required=%0d", cycles, FrameTicks);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok0, ok2, ok1;
    int cycles;
    applyStimulus(0, 8'h3C);
    waitGrant(0, ok0);
    bus.request[0] = 1'b0;
    repeat (44) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.tx, bus.busy, bus.grant, bus.frameDone} !== 6'b10_0000) begin
      errors++;
      $display("[TB] FAIL abort_values tx/busy/grant/done actual=%b/%b/%b/%b required=1/0/000/0",
               bus.tx, bus.busy, bus.grant, bus.frameDone);
    end
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (bus.frameDone !== 1'b0 || bus.tx !== 1'b1) begin
        errors++;
        $display("[TB] FAIL abort_hold tx/done actual=%b/%b required=1/0", bus.tx, bus.frameDone);
      end
    end
    reset = 1'b1;
    applyStimulus(0, 8'hA5);
    applyStimulus(2, 8'h5A);
    waitGrant(0, ok0);
    bus.request[0] = 1'b0;
    waitGrant(2, ok2);
    bus.request[2] = 1'b0;
    applyStimulus(1, 8'hE1);
    waitGrant(1, ok1);
    bus.request[1] = 1'b0;
    waitDone(cycles, ok1);
    checks++;
    if (!(ok0 && ok2 && ok1)) begin
      errors++;
      $display("[TB] FAIL post_reset_service grants 0/2/1 seen actual=%0b/%0b/%0b required=1/1/1", ok0, ok2, ok1);
    end
  endtask

  initial begin
    bus.request = '0;
    bus.data    = '0;
    fork
      monitorFrames();
      monitorGrants();
    join_none
    test_reset();
    test_single_frame();
    test_round_robin();
    test_late_request();
    test_parity_frame();
    test_reset_midframe();
    repeat (20) @(negedge clock);
    checks++;
    if (expByteQ.size() != 0 || expGrantQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_expectations bytes/grants actual=%0d/%0d required=0/0",
               expByteQ.size(), expGrantQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
